// File: rtl/mem_arbiter_if.sv
// Bundle of cache request/response, memory command/completion and status signals for mem_arbiter.
// Latency: none, wiring only.
// Backpressure: the arbiter drives the *_ready and mem_is_input_valid handshakes. The environment drives mem_is_ready.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    // I-cache side: line reads only
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_resp_valid;
    logic [LINE_W-1:0] i_resp_data;

    // D-cache side: line reads and writebacks
    logic              d_req_valid;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_req_addr;
    logic [LINE_W-1:0] d_req_data;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [LINE_W-1:0] d_resp_data;

    // Shared main memory
    logic              mem_is_input_valid;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_din;
    logic              mem_is_ready;
    logic              mem_is_output_valid;
    logic [LINE_W-1:0] mem_dout;

    // Status
    logic              grant_id;
    logic              busy;

    // Arbiter view
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din,
        input  mem_is_ready, mem_is_output_valid, mem_dout,
        output grant_id, busy
    );

    // Environment view: both caches plus the memory
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din,
        output mem_is_ready, mem_is_output_valid, mem_dout,
        input  grant_id, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: shares one multi-cycle main memory between the I-cache and D-cache line paths.
// Latency: 3 cycles plus memory latency from handshake to resp_valid. One IDLE cycle separates transactions.
// Backpressure: one transaction in flight. Ready goes only to the IDLE winner. The memory command is held until mem_is_ready.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Command latched at the handshake. It drives mem_* for the whole transaction.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              grant_q, grant_d;      // 0 = I, 1 = D
    logic              last_q, last_d;        // last grant, reset to D so I wins the first tie
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_i, pick_d;

    // State and datapath registers. Reset clears everything and drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Next state: arbitration in IDLE, command hold in ISSUE, completion capture in WAIT.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        grant_d   = grant_q;
        last_d    = last_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        pick_i    = 1'b0;
        pick_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // D wins when alone, or on a tie when I was served last.
                pick_d = bus.d_req_valid & (~bus.i_req_valid | ~last_q);
                pick_i = bus.i_req_valid & ~pick_d;
                if (pick_i || pick_d) begin
                    cmd_d.write = pick_d & bus.d_req_write;
                    cmd_d.addr  = pick_d ? bus.d_req_addr : bus.i_req_addr;
                    cmd_d.data  = pick_d ? bus.d_req_data : '0;
                    grant_d     = pick_d;
                    last_d      = pick_d;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_is_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Completions outside WAIT are not expected and are ignored.
                if (bus.mem_is_output_valid) begin
                    state_d = RESP;
                    if (grant_q) begin
                        d_rdata_d = cmd_q.write ? '0 : bus.mem_dout;
                    end else begin
                        i_rdata_d = bus.mem_dout;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is combinational, so it is gated by reset to keep every output low during reset.
    assign bus.i_req_ready        = pick_i & reset;
    assign bus.d_req_ready        = pick_d & reset;

    assign bus.mem_is_input_valid = (state_q == ISSUE);
    assign bus.mem_read           = (state_q == ISSUE) & ~cmd_q.write;
    assign bus.mem_write          = (state_q == ISSUE) &  cmd_q.write;
    assign bus.mem_addr           = cmd_q.addr;
    assign bus.mem_din            = cmd_q.data;

    assign bus.i_resp_valid       = (state_q == RESP) & ~grant_q;
    assign bus.d_resp_valid       = (state_q == RESP) &  grant_q;
    assign bus.i_resp_data        = i_rdata_q;
    assign bus.d_resp_data        = d_rdata_q;

    assign bus.grant_id           = grant_q;
    assign bus.busy               = (state_q != IDLE);

    // At most one requester is accepted per cycle.
    a_one_ready: assert property (@(posedge clk) disable iff (!reset)
        !(bus.i_req_ready && bus.d_req_ready));

    // A response pulse goes to one requester only.
    a_one_resp: assert property (@(posedge clk) disable iff (!reset)
        !(bus.i_resp_valid && bus.d_resp_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. A transaction-level reference model is compared against every DUT output each cycle.
// Latency: not applicable.
// Backpressure: the bench memory stalls mem_is_ready at random and has a random completion latency.
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int PB    = 1500;   // start of the sustained-contention phase
    localparam int PC    = 2100;   // start of the random-reset phase
    localparam int N_CYC = 3600;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents. A line that has never been written reads as a fixed pattern of its address.
    function automatic logic [LW-1:0] line_pat(input logic [AW-1:0] a);
        return {a ^ 32'hAAAA_0000, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 32'h100 + (AW'($urandom_range(0, 15)) << 4);
    endfunction

    // Bench memory (environment)
    logic [LW-1:0] env_mem [logic [AW-1:0]];
    bit            env_busy;
    int            env_cnt;
    bit            env_wr;
    logic [AW-1:0] env_addr;

    // Reference model: current transaction record plus arbitration history
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    bit            m_act, m_sent, m_got, m_own, m_gid, m_last, m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_din, m_rd_i, m_rd_d;

    // Expected values for the current cycle, and DUT values sampled for the environment
    bit            e_ri, e_rd, e_miv, e_mrd, e_mwr, e_iv, e_dv;
    bit            i_acc, d_acc;
    bit            s_miv, s_mrdy, s_mwr;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_din;
    int            rst_cnt;
    int            phase;
    int            alt_n;

    function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : line_pat(a);
    endfunction

    task automatic model_reset();
        m_act  = 0; m_sent = 0; m_got = 0; m_own = 0; m_gid = 0;
        m_last = 1; m_wr = 0;   m_addr = '0; m_din = '0;
        m_rd_i = '0; m_rd_d = '0;
        i_acc  = 0; d_acc = 0;
    endtask

    // Drives the inputs for one cycle, starting just after the rising edge.
    task automatic drive_step(input int cyc);
        // Reset control
        if (cyc == PB || cyc == PB + 1) begin
            reset = 1'b0;
            rst_cnt = 0;
            bus.i_req_valid = 1'b0;
            bus.d_req_valid = 1'b0;
            i_acc = 0; d_acc = 0;
        end else if (!reset) begin
            if (rst_cnt > 0) rst_cnt--;
            if (rst_cnt == 0) reset = 1'b1;
        end else if (phase == 2 && $urandom_range(0, 79) == 0) begin
            reset = 1'b0;
            rst_cnt = $urandom_range(1, 3);
        end
        if (!reset) model_reset();

        // Requesters
        if (!(cyc == PB || cyc == PB + 1)) begin
            if (i_acc) bus.i_req_valid = 1'b0;
            else if (bus.i_req_valid && phase != 1 && $urandom % 64 == 0) bus.i_req_valid = 1'b0;
            if (!bus.i_req_valid && (phase == 1 || $urandom % 4 == 0)) begin
                bus.i_req_valid = 1'b1;
                bus.i_req_addr  = rand_addr();
            end
            if (d_acc) bus.d_req_valid = 1'b0;
            else if (bus.d_req_valid && phase != 1 && $urandom % 64 == 0) bus.d_req_valid = 1'b0;
            if (!bus.d_req_valid && (phase == 1 || $urandom % 4 == 0)) begin
                bus.d_req_valid = 1'b1;
                bus.d_req_write = 1'($urandom % 2);
                bus.d_req_addr  = rand_addr();
                bus.d_req_data  = rand_line();
            end
        end
        i_acc = 0; d_acc = 0;

        // Memory: scheduled completion, otherwise occasional spurious pulses
        bus.mem_is_output_valid = 1'b0;
        if (env_busy) begin
            env_cnt--;
            if (env_cnt == 0) begin
                env_busy = 0;
                bus.mem_is_output_valid = 1'b1;
                bus.mem_dout = env_wr ? rand_line()
                             : (env_mem.exists(env_addr) ? env_mem[env_addr] : line_pat(env_addr));
            end
        end else if ($urandom % 16 == 0) begin
            bus.mem_is_output_valid = 1'b1;
            bus.mem_dout = rand_line();
        end
        bus.mem_is_ready = !env_busy && ($urandom % 10 < 7);
    endtask

    // Mid-cycle: compute the model's expected outputs and compare every DUT output.
    task automatic eval_and_check(input int cyc);
        if (!reset) begin
            e_ri = 0; e_rd = 0; e_miv = 0; e_mrd = 0; e_mwr = 0; e_iv = 0; e_dv = 0;
        end else begin
            e_ri  = !m_act && bus.i_req_valid && (!bus.d_req_valid || m_last);
            e_rd  = !m_act && bus.d_req_valid && (!bus.i_req_valid || !m_last);
            e_miv = m_act && !m_sent;
            e_mrd = e_miv && !m_wr;
            e_mwr = e_miv && m_wr;
            e_iv  = m_got && !m_own;
            e_dv  = m_got && m_own;
        end
        check_eq("i_req_ready",  LW'(bus.i_req_ready),        LW'(e_ri));
        check_eq("d_req_ready",  LW'(bus.d_req_ready),        LW'(e_rd));
        check_eq("mem_valid",    LW'(bus.mem_is_input_valid), LW'(e_miv));
        check_eq("mem_read",     LW'(bus.mem_read),           LW'(e_mrd));
        check_eq("mem_write",    LW'(bus.mem_write),          LW'(e_mwr));
        check_eq("mem_addr",     LW'(bus.mem_addr),           LW'(m_addr));
        check_eq("mem_din",      bus.mem_din,                 m_din);
        check_eq("i_resp_valid", LW'(bus.i_resp_valid),       LW'(e_iv));
        check_eq("d_resp_valid", LW'(bus.d_resp_valid),       LW'(e_dv));
        check_eq("i_resp_data",  bus.i_resp_data,             m_rd_i);
        check_eq("d_resp_data",  bus.d_resp_data,             m_rd_d);
        check_eq("grant_id",     LW'(bus.grant_id),           LW'(m_gid));
        check_eq("busy",         LW'(bus.busy),               LW'(m_act && reset));
        // Sustained contention after reset: grants must go I, D, I, D, ...
        if (phase == 1 && cyc >= PB + 2 && (bus.i_req_ready || bus.d_req_ready)) begin
            check_eq("alt_order", LW'(bus.d_req_ready), LW'(alt_n % 2));
            alt_n++;
        end
        s_miv  = bus.mem_is_input_valid;
        s_mrdy = bus.mem_is_ready;
        s_mwr  = bus.mem_write;
        s_addr = bus.mem_addr;
        s_din  = bus.mem_din;
    endtask

    // At the rising edge: advance the reference model and the memory environment.
    task automatic advance();
        if (reset) begin
            i_acc = e_ri;
            d_acc = e_rd;
            if (e_ri || e_rd) begin
                m_act  = 1; m_sent = 0; m_got = 0;
                m_own  = e_rd; m_gid = e_rd; m_last = e_rd;
                m_wr   = e_rd && bus.d_req_write;
                m_addr = e_rd ? bus.d_req_addr : bus.i_req_addr;
                m_din  = e_rd ? bus.d_req_data : '0;
            end else if (m_act && !m_sent) begin
                if (bus.mem_is_ready) begin
                    m_sent = 1;
                    if (m_wr) ref_mem[m_addr] = m_din;
                end
            end else if (m_act && !m_got) begin
                if (bus.mem_is_output_valid) begin
                    m_got = 1;
                    if (m_own) m_rd_d = m_wr ? '0 : ref_read(m_addr);
                    else       m_rd_i = ref_read(m_addr);
                end
            end else if (m_got) begin
                m_act = 0;
                m_got = 0;
            end
        end
        if (s_miv && s_mrdy) begin
            env_busy = 1;
            env_cnt  = $urandom_range(1, 6);
            env_wr   = s_mwr;
            env_addr = s_addr;
            if (s_mwr) env_mem[s_addr] = s_din;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.i_req_valid = 1'b0; bus.i_req_addr = '0;
        bus.d_req_valid = 1'b0; bus.d_req_write = 1'b0;
        bus.d_req_addr  = '0;   bus.d_req_data  = '0;
        bus.mem_is_ready = 1'b0; bus.mem_is_output_valid = 1'b0; bus.mem_dout = '0;
        env_busy = 0; env_cnt = 0; env_wr = 0; env_addr = '0;
        alt_n = 0; rst_cnt = 2; phase = 0;
        model_reset();
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            phase = (cyc < PB) ? 0 : ((cyc < PC) ? 1 : 2);
            drive_step(cyc);
            @(negedge clk);
            eval_and_check(cyc);
            @(posedge clk);
            advance();
            #1;
        end
        // The contention phase must have produced a steady stream of alternating grants.
        n_checks++;
        if (alt_n < 20) begin
            n_errors++;
            $display("FAIL alt_grants: got %0d grants expected at least 20", alt_n);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
